fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared types and default sizes for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state (IDLE between grants, BURST while a
//                 requester owns the FIFO write port).
//   FIFO_WIDTH  : default FIFO data width.
//   MAX_BURST   : default maximum words written per grant.
//   BEAT_W      : width of the per-grant beat counter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int FIFO_WIDTH = 16;
  localparam int MAX_BURST  = 4;
  localparam int BEAT_W     = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_wr_arbiter_rr_pick
//   Combinational round-robin picker. Searches req starting at
//   last_winner+1 and wrapping around; the first set bit wins.
//   Ports:
//     req         in  NUM_REQ  request vector
//     last_winner in  IDX_W    index of the previous grant holder
//     winner      out IDX_W    index of the selected requester
//     any_req     out 1        at least one request is set
module fifo_wr_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = last_winner;
    // Walk NUM_REQ positions after last_winner; last_winner itself is
    // visited last, so a lone requester can win back-to-back grants.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the FIFO write port between NUM_REQ producers using
//   round-robin arbitration with bursts of up to MAX_BURST words.
//   Writes are gated by fifo_full, and the FIFO's registered wr_ack /
//   overflow responses are routed back to the requester that issued
//   the corresponding write.
//   Ports:
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     req            per-requester write request
//     req_data       packed write data, slice i belongs to requester i
//     gnt            registered one-hot grant
//     fifo_wr_en     FIFO write enable
//     fifo_data_in   FIFO write data
//     fifo_full      FIFO full flag
//     fifo_wr_ack    FIFO write acknowledge (one cycle after wr_en)
//     fifo_overflow  FIFO overflow (one cycle after wr_en)
//     ack, ovf       per-requester routed responses
//     busy           high while in BURST
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = fifo_wr_arbiter_pkg::FIFO_WIDTH,
  parameter int MAX_BURST  = fifo_wr_arbiter_pkg::MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            ovf,
  output logic                          busy
);

  import fifo_wr_arbiter_pkg::*;

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  arb_state_e        state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   last_winner_reg;
  logic [BEAT_W-1:0]  beat_cnt_reg;
  logic               busy_reg;
  logic               pend_valid_reg;
  logic [IDX_W-1:0]   pend_owner_reg;

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic               in_burst;
  logic               owner_req;

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner_reg),
    .winner      (winner),
    .any_req     (any_req)
  );

  assign in_burst  = (state_reg == BURST);
  assign owner_req = req[owner_reg];

  // Write issue is combinational from registered state so the owner's
  // data goes out in the same cycle it is presented.
  assign fifo_wr_en   = in_burst & owner_req & ~fifo_full;
  assign fifo_data_in = in_burst ? req_data[owner_reg*FIFO_WIDTH +: FIFO_WIDTH] : '0;

  assign gnt  = gnt_reg;
  assign busy = busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      owner_reg       <= '0;
      last_winner_reg <= IDX_W'(NUM_REQ - 1);
      beat_cnt_reg    <= '0;
      busy_reg        <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_owner_reg  <= '0;
    end else begin
      // Remember who issued this cycle's write; the FIFO answers one
      // cycle later, possibly after ownership has already moved on.
      pend_valid_reg <= fifo_wr_en;
      if (fifo_wr_en) begin
        pend_owner_reg <= owner_reg;
      end

      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg       <= BURST;
            gnt_reg         <= NUM_REQ'(1) << winner;
            owner_reg       <= winner;
            last_winner_reg <= winner;
            beat_cnt_reg    <= '0;
            busy_reg        <= 1'b1;
          end
        end
        BURST: begin
          if (fifo_wr_en) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
          // A full stall neither counts a beat nor ends the burst; only a
          // dropped request or the final beat releases the grant.
          if (!owner_req || (fifo_wr_en && (beat_cnt_reg == LAST_BEAT))) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
      assign ack[gi] = pend_valid_reg & fifo_wr_ack   & (pend_owner_reg == IDX_W'(gi));
      assign ovf[gi] = pend_valid_reg & fifo_overflow & (pend_owner_reg == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data;
  logic           fifo_full = 1'b0;
  logic           fack_force = 1'b0;
  logic           fovf_force = 1'b0;
  logic           stub_ack = 1'b0;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic [N-1:0]   gnt;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [N-1:0]   ack;
  logic [N-1:0]   ovf;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Fixed per-requester data: r0=A5A5, r1=1111, r2=2222, r3=3333
  assign req_data = {16'h3333, 16'h2222, 16'h1111, 16'hA5A5};

  // FIFO stand-in: acknowledges each write one cycle later (not reset,
  // so a stale ack is visible while the arbiter is held in reset).
  always @(posedge clk) stub_ack <= fifo_wr_en;
  assign fifo_wr_ack   = stub_ack | fack_force;
  assign fifo_overflow = fovf_force;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .FIFO_WIDTH (W),
    .MAX_BURST  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_wr_ack   (fifo_wr_ack),
    .fifo_overflow (fifo_overflow),
    .ack           (ack),
    .ovf           (ovf),
    .busy          (busy)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         full;
    logic         fack;
    logic         fovf;
    logic [N-1:0] gnt;
    logic         wr;
    logic [W-1:0] data;
    logic [N-1:0] ack;
    logic [N-1:0] ovf;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [N-1:0] rq, input logic fl,
                              input logic fa, input logic fo, input logic [N-1:0] g,
                              input logic wr, input logic [W-1:0] d, input logic [N-1:0] a,
                              input logic [N-1:0] o, input logic b);
    vec_t v;
    v.rst = rst; v.req = rq; v.full = fl; v.fack = fa; v.fovf = fo;
    v.gnt = g; v.wr = wr; v.data = d; v.ack = a; v.ovf = o; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock cycle of stimulus; outputs are checked at the following negedge.
  task automatic step(input logic [N-1:0] rq, input logic fl);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = rq; fifo_full = fl; fack_force = 1'b0; fovf_force = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [N-1:0] eg, input logic ew,
                     input logic [N-1:0] ea, input logic eb);
    check({tag, " gnt"},  16'(gnt),        16'(eg));
    check({tag, " wr"},   16'(fifo_wr_en), 16'(ew));
    check({tag, " ack"},  16'(ack),        16'(ea));
    check({tag, " busy"}, 16'(busy),       16'(eb));
    $display("[TB] %s req=%b full=%b gnt=%b wr=%b data=%h ack=%b busy=%b",
             tag, req, fifo_full, gnt, fifo_wr_en, fifo_data_in, ack, busy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; req = '0; fifo_full = 1'b0; fack_force = 1'b0; fovf_force = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] dval(input int i);
    case (i)
      0:       return 16'hA5A5;
      1:       return 16'h1111;
      2:       return 16'h2222;
      default: return 16'h3333;
    endcase
  endfunction

  initial begin
    // ---------------- table-driven vectors ----------------
    // single requester 0: four beats, one IDLE cycle, re-grant, drop
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 1, 16'hA5A5, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 1, 16'hA5A5, 4'b0001, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 1, 16'hA5A5, 4'b0001, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 1, 16'hA5A5, 4'b0001, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0001, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0001, 0, 16'hA5A5, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    // early release by requester 2 after one write, then spurious responses
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 1, 16'h2222, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0100, 0, 16'h2222, 4'b0100, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    // requester 1 write answered with overflow; overflow later is ignored
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 16'h1111, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'b0010, 0, 16'h1111, 4'b0010, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    // reset during requester 1's second beat, then restart from requester 0
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 16'h1111, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0010, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 1, 16'hA5A5, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0001, 0, 16'hA5A5, 4'b0001, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0));

    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n      = !vecs[i].rst;
      req        = vecs[i].req;
      fifo_full  = vecs[i].full;
      fack_force = vecs[i].fack;
      fovf_force = vecs[i].fovf;
      @(negedge clk);
      check($sformatf("v%0d gnt", i),  16'(gnt),          16'(vecs[i].gnt));
      check($sformatf("v%0d wr", i),   16'(fifo_wr_en),   16'(vecs[i].wr));
      check($sformatf("v%0d data", i), fifo_data_in,      vecs[i].data);
      check($sformatf("v%0d ack", i),  16'(ack),          16'(vecs[i].ack));
      check($sformatf("v%0d ovf", i),  16'(ovf),          16'(vecs[i].ovf));
      check($sformatf("v%0d busy", i), 16'(busy),         16'(vecs[i].busy));
      $display("[TB] vec %0d rst=%b req=%b full=%b gnt=%b wr=%b data=%h ack=%b ovf=%b busy=%b",
               i, vecs[i].rst, req, fifo_full, gnt, fifo_wr_en, fifo_data_in, ack, ovf, busy);
    end

    // ---------------- all requesters: order 0,1,2,3,0 ----------------
    do_reset();
    step(4'b1111, 1'b0);
    chk("rr idle0", 4'b0000, 1'b0, 4'b0000, 1'b0);
    begin
      int order[5];
      order = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        for (int b = 0; b < 4; b++) begin
          step(4'b1111, 1'b0);
          chk($sformatf("rr g%0d b%0d", k, b), 4'(1 << order[k]), 1'b1,
              (b == 0) ? 4'b0000 : 4'(1 << order[k]), 1'b1);
          check($sformatf("rr g%0d b%0d data", k, b), fifo_data_in, dval(order[k]));
        end
        step(4'b1111, 1'b0);
        chk($sformatf("rr idle after g%0d", k), 4'b0000, 1'b0, 4'(1 << order[k]), 1'b0);
      end
    end

    // ---------------- full stall mid-burst ----------------
    do_reset();
    step(4'b0001, 1'b0); chk("stall idle",   4'b0000, 1'b0, 4'b0000, 1'b0);
    step(4'b0001, 1'b0); chk("stall w1",     4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b0001, 1'b0); chk("stall w2",     4'b0001, 1'b1, 4'b0001, 1'b1);
    step(4'b0001, 1'b1); chk("stall full1",  4'b0001, 1'b0, 4'b0001, 1'b1);
    step(4'b0001, 1'b1); chk("stall full2",  4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0001, 1'b1); chk("stall full3",  4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0001, 1'b0); chk("stall w3",     4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b0001, 1'b0); chk("stall w4",     4'b0001, 1'b1, 4'b0001, 1'b1);
    step(4'b0001, 1'b0); chk("stall end",    4'b0000, 1'b0, 4'b0001, 1'b0);
    // req drops in the same cycle fifo_full rises: no write, burst ends
    step(4'b0000, 1'b1); chk("drop+full",    4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0000, 1'b0); chk("drop idle",    4'b0000, 1'b0, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
